countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Kitchen-timer mode for the stopwatch board.
- Counts down from a loaded MM:SS preset to 00:00 and raises a done flag when it gets there.
- Digits d0..d3 use the same BCD layout the stopwatch counter produces, so seven_seg drives the display unchanged.
- Takes conditioned single-cycle control pulses: start_stop and load.

Parameters:
- CLK_HZ, 100_000_000: system clock frequency.
- TICK_DIV, CLK_HZ: clocks per one-second decrement. The bench overrides this to 4.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start_stop  in  1  one-cycle pulse. Starts, pauses or resumes the count; acknowledges done.
- load  in  1  one-cycle pulse. Latches p0..p3 as the preset.
- p0  in  4  preset seconds ones, BCD.
- p1  in  4  preset seconds tens, BCD.
- p2  in  4  preset minutes ones, BCD.
- p3  in  4  preset minutes tens, BCD.
- d0  out  4  seconds ones, BCD 0-9.
- d1  out  4  seconds tens, BCD 0-5.
- d2  out  4  minutes ones, BCD 0-9.
- d3  out  4  minutes tens, BCD 0-9.
- running  out  1  high while in RUN.
- done  out  1  level, high in DONE.
- expired  out  1  one-cycle pulse on entry to DONE.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, d0..d3=0, preset register=0, prescaler=0, running=0, done=0, expired=0.
- Preset sanitizing at load time:
  - p0, p2, p3 values >9 clamp to 9.
  - p1 values >5 clamp to 5.
  - The sanitized value goes into both the preset register and d0..d3.
- State machine: IDLE, RUN, PAUSE, DONE. Registered; outputs change on the clk edge after the input pulse.
  - load, any state: go to IDLE, d=sanitized preset, prescaler=0. load has priority over start_stop in the same cycle.
  - IDLE + start_stop: go to RUN if d != 00:00, otherwise stay in IDLE.
  - RUN + start_stop: go to PAUSE. Prescaler holds its value, so resume does not lose the partial second.
  - PAUSE + start_stop: go to RUN.
  - DONE + start_stop: go to IDLE, d reloads from the preset register, done drops.
- Prescaler, active only in RUN:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - A tick occurs in the cycle where the count equals TICK_DIV-1.
  - First tick comes TICK_DIV cycles after entering RUN from IDLE.
- Decrement on tick, BCD with borrow:
  - d0 -1. When d0=0: d0=9 and borrow to d1.
  - d1 borrow: 0 becomes 5, and borrow to d2.
  - d2 borrow: 0 becomes 9, and borrow to d3.
  - d3 never borrows below 0.
  - Example: 10:00 decrements to 09:59.
- Expiry:
  - A tick that produces 00:00 moves to DONE in the same edge.
  - expired=1 for exactly that one cycle; done=1 until acknowledged or loaded.
  - d holds at 00:00 in DONE; no wrap to 99:59.
- Tick and start_stop in the same cycle in RUN: the decrement is applied, then go to PAUSE. If that tick reaches 00:00, DONE wins and start_stop is ignored.
- running = (state==RUN). No combinational path from inputs to outputs.
- Reset asserted mid-count returns to the reset values immediately. The preset is lost.

Decomposition:
- stopwatch_pkg holds:
  - the state enum t_cd_state {IDLE, RUN, PAUSE, DONE};
  - localparams DIGIT_W=4, SEC_TENS_MAX=5, DIGIT_MAX=9;
  - the shared digit typedef t_bcd (logic [3:0]), also used by counter and seven_seg.
- One sub-module, tick_gen: prescaler with enable and clear inputs, producing a one-cycle tick. The enable-gated and clear-on-load behaviour is the reason it is split out.
- BCD borrow chain and FSM stay in countdown_timer.

Test Plan (TICK_DIV=4):
- Release reset, load p=0,3,0,0 (00:30), pulse start_stop → running=1; after 4 clks d=00:29; after 120 clks from start, expired pulses once, done=1, d=00:00.
- Load 10:00, run 1 tick → d3=0, d2=9, d1=5, d0=9 (09:59).
- Load 01:05, start, pause after 2 clks, wait 50 clks (d unchanged, still 01:05), resume → first decrement to 01:04 after 2 more clks.
- Load p=F,7,C,2 → d=29:59 (clamped); load 00:00 and pulse start_stop → stays IDLE, running=0.
- In DONE, pulse start_stop → IDLE, d=preset, done=0. In RUN, pulse load and start_stop together → IDLE with new preset.
- Drive reset=0 mid-run for 1 ns between edges → all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Types and constants shared by the stopwatch board blocks (counter, seven_seg, countdown_timer).
package stopwatch_pkg;

   localparam int DIGIT_W      = 4;
   localparam int SEC_TENS_MAX = 5;
   localparam int DIGIT_MAX    = 9;

   typedef logic [DIGIT_W-1:0] t_bcd;

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} t_cd_state;

   function automatic t_bcd clamp_bcd(input t_bcd value, input t_bcd limit);
      return (value > limit) ? limit : value;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// One-second prescaler: counts only while enabled, clear overrides enable,
// and emits a single-cycle tick on the last count of each period.
module tick_gen #(
   parameter int unsigned TICK_DIV = 100_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int unsigned   CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] count_reg;
   logic [CNT_W-1:0] count_next;

   always_comb begin
      count_next = count_reg;
      if (clr) begin
         count_next = '0;
      end else if (en) begin
         count_next = (count_reg == LAST) ? '0 : count_reg + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

   // Paused counts keep their value, so a resume finishes the partial second.
   assign tick = en && !clr && (count_reg == LAST);

endmodule

// File: rtl/countdown_timer.sv
// Kitchen timer: counts a sanitized MM:SS preset down to 00:00 in BCD and
// flags completion; digit layout matches the stopwatch counter.
module countdown_timer
   import stopwatch_pkg::*;
#(
   parameter int unsigned CLK_HZ   = 100_000_000,
   parameter int unsigned TICK_DIV = CLK_HZ
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_stop,
   input  logic       load,
   input  logic [3:0] p0,
   input  logic [3:0] p1,
   input  logic [3:0] p2,
   input  logic [3:0] p3,
   output logic [3:0] d0,
   output logic [3:0] d1,
   output logic [3:0] d2,
   output logic [3:0] d3,
   output logic       running,
   output logic       done,
   output logic       expired
);

   t_cd_state state_reg;
   t_cd_state state_next;

   t_bcd d_reg      [4];
   t_bcd preset_reg [4];
   t_bcd p_in       [4];
   t_bcd san        [4];
   t_bcd dec        [4];
   logic [3:0] borrow;

   logic tick;
   logic d_zero;
   logic dec_zero;
   logic expired_reg;

   assign p_in[0] = p0;
   assign p_in[1] = p1;
   assign p_in[2] = p2;
   assign p_in[3] = p3;

   // Units digit always borrows on a tick; each further digit borrows when the
   // one below it underflows. The minutes-tens digit floors at zero.
   assign borrow[0] = 1'b1;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_digit
         localparam t_bcd LIMIT = (gi == 1) ? t_bcd'(SEC_TENS_MAX) : t_bcd'(DIGIT_MAX);
         localparam t_bcd WRAP  = (gi == 3) ? t_bcd'(0) : LIMIT;

         assign san[gi] = clamp_bcd(p_in[gi], LIMIT);
         assign dec[gi] = !borrow[gi]       ? d_reg[gi] :
                          (d_reg[gi] == '0) ? WRAP      :
                                              d_reg[gi] - t_bcd'(1);

         if (gi < 3) begin : g_borrow
            assign borrow[gi+1] = borrow[gi] && (d_reg[gi] == '0);
         end
      end
   endgenerate

   assign d_zero   = (d_reg[0] | d_reg[1] | d_reg[2] | d_reg[3]) == '0;
   assign dec_zero = (dec[0] | dec[1] | dec[2] | dec[3]) == '0;

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk   (clk),
      .reset (reset),
      .en    (state_reg == RUN),
      .clr   (load || (state_reg == IDLE) || (state_reg == DONE)),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      if (load) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE:    if (start_stop && !d_zero) state_next = RUN;
            // Reaching 00:00 outranks a simultaneous pause request.
            RUN:     if (tick && dec_zero)      state_next = DONE;
                     else if (start_stop)       state_next = PAUSE;
            PAUSE:   if (start_stop)            state_next = RUN;
            DONE:    if (start_stop)            state_next = IDLE;
            default:                            state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      running = (state_reg == RUN);
      done    = (state_reg == DONE);
      expired = expired_reg;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         expired_reg <= 1'b0;
      end else begin
         expired_reg <= (state_next == DONE) && (state_reg != DONE);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++) begin
            d_reg[i]      <= '0;
            preset_reg[i] <= '0;
         end
      end else if (load) begin
         for (int i = 0; i < 4; i++) begin
            d_reg[i]      <= san[i];
            preset_reg[i] <= san[i];
         end
      end else if ((state_reg == DONE) && start_stop) begin
         for (int i = 0; i < 4; i++) begin
            d_reg[i] <= preset_reg[i];
         end
      end else if ((state_reg == RUN) && tick) begin
         for (int i = 0; i < 4; i++) begin
            d_reg[i] <= dec[i];
         end
      end
   end

   assign d0 = d_reg[0];
   assign d1 = d_reg[1];
   assign d2 = d_reg[2];
   assign d3 = d_reg[3];

endmodule

// File: tb/tb_countdown_timer.sv
// Randomized and directed bench for countdown_timer against a seconds-based
// reference model; a negedge monitor checks every cycle from a queue.
module tb_countdown_timer;

   localparam int TICK_DIV = 4;
   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_DONE  = 3;

   typedef struct packed {
      logic [3:0] d3;
      logic [3:0] d2;
      logic [3:0] d1;
      logic [3:0] d0;
      logic       running;
      logic       done;
      logic       expired;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start_stop = 1'b0;
   logic       load = 1'b0;
   logic [3:0] p0 = '0, p1 = '0, p2 = '0, p3 = '0;
   logic [3:0] d0, d1, d2, d3;
   logic       running, done, expired;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   // Reference model state: remaining time and preset in whole seconds,
   // cycles elapsed in the current second while running.
   int rem = 0;
   int preset_s = 0;
   int phase = 0;
   int st = M_IDLE;

   always #5 clk = ~clk;

   countdown_timer #(
      .CLK_HZ   (100_000_000),
      .TICK_DIV (TICK_DIV)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start_stop (start_stop),
      .load       (load),
      .p0         (p0),
      .p1         (p1),
      .p2         (p2),
      .p3         (p3),
      .d0         (d0),
      .d1         (d1),
      .d2         (d2),
      .d3         (d3),
      .running    (running),
      .done       (done),
      .expired    (expired)
   );

   function automatic int clampv(input logic [3:0] v, input int lim);
      return (int'(v) > lim) ? lim : int'(v);
   endfunction

   function automatic int preset_secs(input logic [15:0] p);
      int c0, c1, c2, c3;
      c0 = clampv(p[3:0], 9);
      c1 = clampv(p[7:4], 5);
      c2 = clampv(p[11:8], 9);
      c3 = clampv(p[15:12], 9);
      return (c3 * 10 + c2) * 60 + c1 * 10 + c0;
   endfunction

   task automatic model_reset();
      rem = 0;
      preset_s = 0;
      phase = 0;
      st = M_IDLE;
   endtask

   task automatic model_step(input logic ss, input logic ld, input logic [15:0] p,
                             output exp_t e);
      int mm, sec;
      logic exp_pulse;
      exp_pulse = 1'b0;
      if (!reset) begin
         model_reset();
      end else if (ld) begin
         preset_s = preset_secs(p);
         rem = preset_s;
         st = M_IDLE;
         phase = 0;
      end else begin
         case (st)
            M_IDLE:  if (ss && rem != 0) st = M_RUN;
            M_RUN: begin
               phase++;
               if (phase == TICK_DIV) begin
                  phase = 0;
                  rem--;
                  if (rem == 0) begin
                     st = M_DONE;
                     exp_pulse = 1'b1;
                  end
               end
               if (st == M_RUN && ss) st = M_PAUSE;
            end
            M_PAUSE: if (ss) st = M_RUN;
            default: if (ss) begin
               st = M_IDLE;
               rem = preset_s;
            end
         endcase
      end
      mm  = rem / 60;
      sec = rem % 60;
      e.d3 = 4'(mm / 10);
      e.d2 = 4'(mm % 10);
      e.d1 = 4'(sec / 10);
      e.d0 = 4'(sec % 10);
      e.running = (st == M_RUN);
      e.done    = (st == M_DONE);
      e.expired = exp_pulse;
   endtask

   // Drives one cycle of inputs, pushes the expected post-edge outputs.
   task automatic cycle(input logic ss, input logic ld, input logic [15:0] p);
      exp_t e;
      start_stop = ss;
      load = ld;
      {p3, p2, p1, p0} = p;
      model_step(ss, ld, p, e);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      start_stop = 1'b0;
      load = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'($urandom));
   endtask

   always @(negedge clk) begin
      exp_t e, got;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         got = '{d3, d2, d1, d0, running, done, expired};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL outputs t=%0t: got d=%h%h:%h%h run=%b done=%b exp=%b, required d=%h%h:%h%h run=%b done=%b exp=%b",
                     $time, got.d3, got.d2, got.d1, got.d0, got.running, got.done, got.expired,
                     e.d3, e.d2, e.d1, e.d0, e.running, e.done, e.expired);
         end
      end
   end

   initial begin
      logic ss, ld;
      logic [15:0] p;

      // Reset held, then released away from the clock edge.
      idle(3);
      reset = 1'b1;
      idle(2);

      // 00:30 full run to expiry, then acknowledge.
      cycle(1'b0, 1'b1, 16'h0030);
      cycle(1'b1, 1'b0, 16'h0);
      idle(124);
      cycle(1'b1, 1'b0, 16'h0);
      idle(2);

      // 10:00 -> 09:59 borrow across all digits.
      cycle(1'b0, 1'b1, 16'h1000);
      cycle(1'b1, 1'b0, 16'h0);
      idle(6);

      // 01:05 pause/resume keeps the partial second.
      cycle(1'b0, 1'b1, 16'h0105);
      cycle(1'b1, 1'b0, 16'h0);
      idle(1);
      cycle(1'b1, 1'b0, 16'h0);
      idle(50);
      cycle(1'b1, 1'b0, 16'h0);
      idle(6);

      // Clamping, and start refused at 00:00.
      cycle(1'b0, 1'b1, 16'h2C7F);
      idle(2);
      cycle(1'b0, 1'b1, 16'h0000);
      cycle(1'b1, 1'b0, 16'h0);
      idle(3);

      // Short run to DONE, acknowledge, then load+start_stop together in RUN.
      cycle(1'b0, 1'b1, 16'h0002);
      cycle(1'b1, 1'b0, 16'h0);
      idle(10);
      cycle(1'b1, 1'b0, 16'h0);
      cycle(1'b1, 1'b0, 16'h0);
      idle(3);
      cycle(1'b1, 1'b1, 16'h0145);
      idle(3);

      // Tick coinciding with start_stop: 00:01 expires despite the pause pulse.
      cycle(1'b0, 1'b1, 16'h0001);
      cycle(1'b1, 1'b0, 16'h0);
      idle(3);
      cycle(1'b1, 1'b0, 16'h0);
      idle(2);

      // Asynchronous reset pulse mid-run, between edges.
      cycle(1'b0, 1'b1, 16'h0130);
      cycle(1'b1, 1'b0, 16'h0);
      idle(7);
      @(negedge clk);
      #1;
      reset = 1'b0;
      #1;
      checks++;
      if ({d3, d2, d1, d0, running, done, expired} !== 19'd0) begin
         errors++;
         $display("FAIL async_reset: got d=%h%h:%h%h run=%b done=%b exp=%b, required all zero",
                  d3, d2, d1, d0, running, done, expired);
      end
      reset = 1'b1;
      model_reset();
      cycle(1'b1, 1'b0, 16'h0);
      idle(3);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         ss = ($urandom_range(0, 99) < 4);
         ld = ($urandom_range(0, 199) < 3);
         if ($urandom_range(0, 7) == 0)
            p = 16'($urandom);
         else
            p = {4'd0, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 6)), 4'($urandom_range(0, 9))};
         cycle(ss, ld, p);
      end

      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain: got %0d pending, required 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
